// File: rtl/fifo_pkg.sv
// Shared FIFO types, plus the round-robin pick helper used by the write arbiter.
package fifo_pkg;

  typedef logic [7:0] data_t;
  typedef enum logic {NO_PUSH = 1'b0, PUSH = 1'b1} push_e_t;
  typedef enum logic {NO_POP = 1'b0, POP = 1'b1} pop_e_t;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_PTR_W   = $clog2(ARB_MAX_REQ);

  // One-hot grant to the first set req bit after ptr, wrapping at nreq.
  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
    input logic [ARB_MAX_REQ-1:0] req,
    input logic [ARB_PTR_W-1:0]   ptr,
    input int                     nreq
  );
    logic [ARB_MAX_REQ-1:0] gnt;
    logic [ARB_PTR_W-1:0]   sel;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= ARB_MAX_REQ; k++) begin
      sel = ARB_PTR_W'((int'(ptr) + k) % nreq);
      if (k <= nreq && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick with last-winner pointer; grant is combinational, zero when en is low.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          ptr_nxt;
  logic [ARB_MAX_REQ-1:0] req_ext;
  logic [ARB_MAX_REQ-1:0] pick;
  logic [ARB_PTR_W-1:0]   ptr_ext;
  logic                   unused_pick;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    ptr_ext           = '0;
    ptr_ext[PW-1:0]   = ptr;
  end

  assign pick        = en ? rr_pick(req_ext, ptr_ext, NREQ) : '0;
  assign gnt         = pick[NREQ-1:0];
  // Bits above NREQ are always zero; folded here so they are not left dangling.
  assign unused_pick = ^pick;

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) ptr_nxt = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= PW'(NREQ - 1);
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Credit-tracked round-robin writer onto one FIFO push port: gnt same cycle, push one cycle later;
// no grant while credits are zero. Optional per-requester grant counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  data_t [NREQ-1:0]      req_data,
  output logic [NREQ-1:0]       gnt,
  output push_e_t               push,
  output data_t                 data_in,
  input  logic                  full,
  input  pop_e_t                pop,
  input  logic                  empty,
  output logic [CW-1:0]         credits,
`ifdef FIFO_ARB_STATS_EN
  output logic [NREQ-1:0][15:0] grant_cnt,
`endif
  output logic                  ovf_err
);

  logic          any_gnt;
  logic          pop_acc;
  data_t         gnt_data;
  logic [CW-1:0] credits_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (credits != '0),
    .gnt   (gnt)
  );

  assign any_gnt = |gnt;
  assign pop_acc = (pop == POP) && !empty;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_data = gnt_data | req_data[i];
    end
  end

  // A pop arriving at DEPTH can only be spurious; ignore it rather than wrap.
  always_comb begin
    credits_nxt = credits;
    if (any_gnt && !pop_acc)
      credits_nxt = credits - CW'(1);
    else if (!any_gnt && pop_acc && credits != CW'(DEPTH))
      credits_nxt = credits + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push    <= NO_PUSH;
      data_in <= '0;
      credits <= CW'(DEPTH);
      ovf_err <= 1'b0;
    end else begin
      push    <= any_gnt ? PUSH : NO_PUSH;
      credits <= credits_nxt;
      if (any_gnt) data_in <= gnt_data;
      if (push == PUSH && full) ovf_err <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  data_t [NREQ-1:0]      req_data = '0;
  logic [NREQ-1:0]       gnt;
  push_e_t               push;
  data_t                 data_in;
  logic                  full = 1'b0;
  pop_e_t                pop = NO_POP;
  logic                  empty = 1'b1;
  logic [CW-1:0]         credits;
  logic                  ovf_err;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][15:0] grant_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .push      (push),
    .data_in   (data_in),
    .full      (full),
    .pop       (pop),
    .empty     (empty),
    .credits   (credits),
`ifdef FIFO_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_credits, m_ptr, m_gidx;
  logic        m_push, m_ovf;
  data_t       m_data;
  int unsigned m_cnt [NREQ];
  data_t       fq [$];
  logic [NREQ-1:0]  nx_req = '0;
  data_t [NREQ-1:0] nx_data = '0;
  logic        nx_pop = 1'b0;
  logic        force_full = 1'b0;
  int          glog [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = DEPTH;
    m_ptr     = NREQ - 1;
    m_gidx    = -1;
    m_push    = 1'b0;
    m_data    = '0;
    m_ovf     = 1'b0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    fq.delete();
  endtask

  // One clock: check registers, drive inputs, check grant, advance model and FIFO image.
  task automatic step();
    logic [NREQ-1:0] exp_g;
    logic            pa;
    logic            cap_push;
    data_t           cap_data;
    @(negedge clk);
    chk("push", 64'(push), 64'(m_push));
    chk("data_in", 64'(data_in), 64'(m_data));
    chk("credits", 64'(credits), 64'(m_credits));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("grant_cnt", 64'(grant_cnt[i]), 64'(m_cnt[i]));
`endif
    req      = nx_req;
    req_data = nx_data;
    pop      = nx_pop ? POP : NO_POP;
    full     = force_full || (fq.size() == DEPTH);
    empty    = (fq.size() == 0);
    #1;
    m_gidx = -1;
    if (m_credits != 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_gidx < 0 && req[(m_ptr + k) % NREQ]) m_gidx = (m_ptr + k) % NREQ;
      end
    end
    exp_g = (m_gidx < 0) ? '0 : (NREQ'(1) << m_gidx);
    chk("gnt", 64'(gnt), 64'(exp_g));
    cap_push = (push == PUSH);
    cap_data = data_in;
    @(posedge clk);
    pa = (pop == POP) && !empty;
    if (m_push && full) m_ovf = 1'b1;
    m_push = (m_gidx >= 0);
    if (m_gidx >= 0) begin
      m_data = req_data[m_gidx];
      m_ptr  = m_gidx;
      m_cnt[m_gidx] = (m_cnt[m_gidx] + 1) & 32'hFFFF;
      if (!pa) m_credits--;
    end else if (pa && m_credits < DEPTH) begin
      m_credits++;
    end
    if (pa) void'(fq.pop_front());
    if (cap_push && fq.size() < DEPTH) fq.push_back(cap_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; pop = NO_POP; full = 1'b0; empty = 1'b1;
    nx_req = '0; nx_pop = 1'b0; force_full = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_push", 64'(push), 64'(NO_PUSH));
    chk("rst_data_in", 64'(data_in), 64'd0);
    chk("rst_credits", 64'(credits), 64'(DEPTH));
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("rst_grant_cnt", 64'(grant_cnt[i]), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic gen_rand();
    for (int i = 0; i < NREQ; i++) begin
      if (m_gidx == i || !nx_req[i]) begin
        nx_req[i]  = ($urandom_range(0, 99) < 40);
        nx_data[i] = data_t'($urandom);
      end
    end
    nx_pop = 1'($urandom_range(0, 1));
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle after reset
    repeat (10) step();
    chk("idle_credits", 64'(m_credits), 64'd8);

    // All four requesting, no pops: two full rotations, then starved
    nx_req = 4'b1111;
    for (int i = 0; i < NREQ; i++) nx_data[i] = data_t'(8'hA0 + i);
    for (int c = 0; c < 10; c++) begin
      step();
      glog[c] = m_gidx;
    end
    for (int c = 0; c < 10; c++) chk("burst_gnt", 64'(glog[c]), (c < 8) ? 64'(c % 4) : 64'(-1));
    chk("burst_credits", 64'(m_credits), 64'd0);
    chk("burst_fill", 64'(fq.size()), 64'd8);
    for (int i = 0; i < 8 && i < fq.size(); i++)
      chk("burst_fifo", 64'(fq[i]), 64'(8'hA0 + (i % 4)));

    // From full: one pop frees a credit, req[2] granted the cycle after
    nx_req = 4'b0100; nx_pop = 1'b1;
    step();
    chk("full_pop_gnt", 64'(m_gidx), 64'(-1));
    chk("full_pop_credits", 64'(m_credits), 64'd1);
    nx_pop = 1'b0;
    step();
    chk("refill_gnt", 64'(m_gidx), 64'd2);
    chk("refill_credits", 64'(m_credits), 64'd0);

    // Drain to credits=3, then grant and pop in the same cycle
    nx_req = '0; nx_pop = 1'b1;
    repeat (3) step();
    chk("drain_credits", 64'(m_credits), 64'd3);
    nx_req = 4'b0001;
    step();
    chk("same_cycle_gnt", 64'(m_gidx), 64'd0);
    chk("same_cycle_credits", 64'(m_credits), 64'd3);

    // Single requester with concurrent pops
    nx_req = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      nx_data[1] = data_t'(8'h10 + b);
      step();
      chk("single_gnt", 64'(m_gidx), 64'd1);
    end
    chk("single_credits", 64'(m_credits), 64'd3);
    nx_req = '0; nx_pop = 1'b0;
    step();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      gen_rand();
      step();
    end

    // Reset in the middle of a burst
    do_reset();
    nx_req = 4'b1111;
    for (int i = 0; i < NREQ; i++) nx_data[i] = data_t'(8'hC0 + i);
    repeat (6) step();
    chk("mid_credits", 64'(m_credits), 64'd2);
    chk("mid_push", 64'(m_push), 64'd1);
    do_reset();
    nx_req = 4'b1111;
    step();
    chk("restart_gnt", 64'(m_gidx), 64'd0);

    // Push while full is asserted must latch ovf_err
    nx_req = 4'b0001;
    step();
    nx_req = '0; force_full = 1'b1;
    step();
    force_full = 1'b0;
    repeat (3) step();
    chk("ovf_sticky", 64'(m_ovf), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
